fetch_queue: RTL and testbench

- Instruction buffer between the fetch stage and the decode stage.
- Fetch pushes each {instruction, PC} pair on a valid/ready handshake. Decode pops them in program order.
- Decouples fetch from decode stalls and absorbs branch-redirect flushes.
- Detects HALT in the stream and stops accepting fetches until a flush or reset.

---
 rtl/fetch_queue.sv | 80 ++++++++
 tb/tb_fetch_queue.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode: first-word fall-through circular queue
// of {instr, pc} pairs with flush support and HALT detection.
module fetch_queue #(
    parameter int               DEPTH      = 4,
    parameter int               WIDTH      = 16,
    parameter logic [WIDTH-1:0] NOP_INSTR  = 16'h0800,
    parameter logic [WIDTH-1:0] HALT_INSTR = 16'h0000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_instr,
    input  logic [WIDTH-1:0]           in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_instr,
    output logic [WIDTH-1:0]           out_pc,
    input  logic                       flush,
    output logic                       halted,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_instr [DEPTH];
    logic [WIDTH-1:0] mem_pc    [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic             push;
    logic             pop;

    assign in_ready  = (count < CW'(DEPTH)) && !halted;
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    assign out_instr = out_valid ? mem_instr[head] : NOP_INSTR;
    assign out_pc    = out_valid ? mem_pc[head] : '0;

    // Control state; flush overrides any same-cycle push or pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            halted <= 1'b0;
        end else if (flush) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            halted <= 1'b0;
        end else begin
            if (push) begin
                tail <= tail + PW'(1);
                if (in_instr == HALT_INSTR) begin
                    halted <= 1'b1;
                end
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage carries no reset; the occupancy count masks stale contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[tail] <= in_instr;
            mem_pc[tail]    <= in_pc;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_fetch_queue;

    localparam int          DEPTH = 4;
    localparam int          WIDTH = 16;
    localparam logic [15:0] NOP   = 16'h0800;
    localparam logic [15:0] HALT  = 16'h0000;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_instr = '0;
    logic [WIDTH-1:0] in_pc = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_instr;
    logic [WIDTH-1:0] out_pc;
    logic             flush = 1'b0;
    logic             halted;
    logic [2:0]       count;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
    } ent_t;

    ent_t mq[$];
    bit   m_halted = 1'b0;

    fetch_queue #(
        .DEPTH(DEPTH), .WIDTH(WIDTH), .NOP_INSTR(NOP), .HALT_INSTR(HALT)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .flush(flush), .halted(halted), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        int n;
        n = mq.size();
        check({tag, ".count"},     32'(count),     32'(n));
        check({tag, ".in_ready"},  32'(in_ready),  32'((n < DEPTH) && !m_halted));
        check({tag, ".out_valid"}, 32'(out_valid), 32'(n != 0));
        check({tag, ".out_instr"}, 32'(out_instr), 32'((n != 0) ? mq[0].instr : NOP));
        check({tag, ".out_pc"},    32'(out_pc),    32'((n != 0) ? mq[0].pc : 16'h0));
        check({tag, ".halted"},    32'(halted),    32'(m_halted));
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then compare.
    task automatic cycle(input string tag, input bit v, input logic [15:0] instr,
                         input logic [15:0] pc, input bit rdy, input bit fl);
        bit   mpush;
        bit   mpop;
        ent_t e;
        in_valid  = v;
        in_instr  = instr;
        in_pc     = pc;
        out_ready = rdy;
        flush     = fl;
        mpush = v && (mq.size() < DEPTH) && !m_halted && !fl;
        mpop  = (mq.size() != 0) && rdy && !fl;
        @(posedge clk);
        if (fl) begin
            mq.delete();
            m_halted = 1'b0;
        end else begin
            if (mpop) void'(mq.pop_front());
            if (mpush) begin
                e.instr = instr;
                e.pc    = pc;
                mq.push_back(e);
                if (instr == HALT) m_halted = 1'b1;
            end
        end
        #1;
        check_model(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state while rst is held low
        #12;
        check("rst.count",     32'(count),     32'd0);
        check("rst.in_ready",  32'(in_ready),  32'd1);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.out_instr", 32'(out_instr), 32'(NOP));
        check("rst.out_pc",    32'(out_pc),    32'd0);
        check("rst.halted",    32'(halted),    32'd0);
        rst = 1'b1;

        // Three pushes with decode stalled
        cycle("p3a", 1, 16'h1234, 16'd0, 0, 0);
        cycle("p3b", 1, 16'h5678, 16'd2, 0, 0);
        cycle("p3c", 1, 16'h9ABC, 16'd4, 0, 0);
        check("p3.count", 32'(count), 32'd3);
        check("p3.instr", 32'(out_instr), 32'h1234);
        check("p3.pc",    32'(out_pc), 32'd0);
        cycle("fl0", 0, 16'h0, 16'h0, 0, 1);

        // Fill, overflow attempt, then drain in order
        for (int i = 0; i < 4; i++) cycle("fill", 1, 16'(16'h100 + i), 16'(2 * i), 0, 0);
        check("full.count",    32'(count),    32'd4);
        check("full.in_ready", 32'(in_ready), 32'd0);
        cycle("ovf", 1, 16'hAAAA, 16'd8, 0, 0);
        check("ovf.count", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("drain.pc", 32'(out_pc), 32'(2 * i));
            cycle("drain", 0, 16'h0, 16'h0, 1, 0);
        end
        check("empty.valid", 32'(out_valid), 32'd0);
        check("empty.instr", 32'(out_instr), 32'(NOP));

        // Streaming push+pop, pointers wrap
        cycle("st0", 1, 16'h3000, 16'd100, 1, 0);
        for (int k = 0; k < 10; k++) begin
            cycle("stream", 1, 16'(16'h3001 + k), 16'(102 + 2 * k), 1, 0);
            check("stream.count", 32'(count), 32'd1);
            check("stream.pc", 32'(out_pc), 32'(102 + 2 * k));
        end
        cycle("st_end", 0, 16'h0, 16'h0, 1, 0);

        // HALT detection
        cycle("h1", 1, 16'h1111, 16'd10, 0, 0);
        cycle("h2", 1, HALT,     16'd12, 0, 0);
        check("halt.halted",   32'(halted),   32'd1);
        check("halt.in_ready", 32'(in_ready), 32'd0);
        cycle("h3", 1, 16'h2222, 16'd14, 0, 0);
        check("halt.count", 32'(count), 32'd2);
        check("halt.head0", 32'(out_instr), 32'h1111);
        cycle("hd1", 0, 16'h0, 16'h0, 1, 0);
        check("halt.head1", 32'(out_instr), 32'h0000);
        cycle("hd2", 0, 16'h0, 16'h0, 1, 0);
        check("halt.drained", 32'(halted), 32'd1);
        cycle("hfl", 0, 16'h0, 16'h0, 0, 1);
        check("halt.clear",  32'(halted),   32'd0);
        check("halt.ready",  32'(in_ready), 32'd1);

        // Flush beats simultaneous push and pop
        for (int i = 0; i < 3; i++) cycle("f3", 1, 16'(16'h4000 + i), 16'(20 + 2 * i), 0, 0);
        cycle("fpp", 1, 16'h4444, 16'd40, 1, 1);
        check("flush.count", 32'(count), 32'd0);
        check("flush.valid", 32'(out_valid), 32'd0);
        check("flush.instr", 32'(out_instr), 32'(NOP));

        // Asynchronous reset between edges
        cycle("r1", 1, 16'h5001, 16'd50, 0, 0);
        cycle("r2", 1, 16'h5002, 16'd52, 0, 0);
        in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("arst.count",  32'(count),     32'd0);
        check("arst.valid",  32'(out_valid), 32'd0);
        check("arst.halted", 32'(halted),    32'd0);
        check("arst.instr",  32'(out_instr), 32'(NOP));
        mq.delete();
        m_halted = 1'b0;
        #1 rst = 1'b1;

        // Randomized traffic against the model
        for (int n = 0; n < 500; n++) begin
            logic [15:0] ri;
            ri = ($urandom_range(0, 15) == 0) ? HALT : 16'($urandom_range(1, 16'hFFFF));
            cycle("rand", 1'($urandom_range(0, 3) != 0), ri, 16'($urandom),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
